exec_ctrl_unit: RTL and testbench

- Combined control/execute/sequencing block for a single-cycle, word-addressed MIPS-subset core: instruction decoder + ALU + program counter.
- The surrounding datapath supplies the fetched instruction and the two register-file read values, and owns the register file and data memory.
- The block returns decoded fields, control strobes, the ALU result and zero flag, and the current instruction index.

---
 rtl/exec_ctrl_unit.sv | 165 ++++++++++++++++
 tb/tb_exec_ctrl_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: decoder + ALU + PC for a single-cycle, word-addressed MIPS subset (ALU_SHIFT_EN adds sll/srl).
// Latency: decode/ALU combinational from instr, pc registered each clk; no backpressure (one instruction per cycle).
module exec_ctrl_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic            reg_write,
  output logic            mem_write,
  output logic            mem_read,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump,
  output logic [1:0]      alu_op,
  output logic [31:0]     alu_result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
`ifdef ALU_SHIFT_EN
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
`endif

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  logic            dec_reg_write;
  logic            dec_illegal;
  logic            funct_bad;
  logic [31:0]     imm_sext;
  logic [31:0]     alu_b;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jump_target;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    dec_reg_write = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_op        = ALU_ADD;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        reg_dst       = 1'b1;
        alu_op        = ALU_FUNCT;
      end
      OP_LW: begin
        dec_reg_write = 1'b1;
        mem_read      = 1'b1;
        mem_to_reg    = 1'b1;
        alu_src       = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        alu_src       = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_J:    jump = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_b      = alu_src ? imm_sext : rt_data;
    alu_result = '0;
    funct_bad  = 1'b0;
    case (alu_op)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_FUNCT: begin
        case (funct)
          F_ADD: alu_result = rs_data + alu_b;
          F_SUB: alu_result = rs_data - alu_b;
          F_AND: alu_result = rs_data & alu_b;
          F_OR:  alu_result = rs_data | alu_b;
          F_SLT: alu_result = {31'd0, ($signed(rs_data) < $signed(alu_b))};
`ifdef ALU_SHIFT_EN
          F_SLL: alu_result = rt_data << shamt;
          F_SRL: alu_result = rt_data >> shamt;
`endif
          default: funct_bad = 1'b1;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  // An unsupported funct must not commit a register write.
  assign reg_write = dec_reg_write & ~funct_bad;
  assign illegal   = dec_illegal | funct_bad;
  assign zero      = (alu_result == 32'd0);

  assign pc_plus1  = pc + PC_W'(1);
  assign br_target = pc_plus1 + PC_W'($signed(imm));

  generate
    if (PC_W > 26) begin : g_jump_wide
      assign jump_target = {pc_plus1[PC_W-1:26], instr[25:0]};
    end else begin : g_jump_narrow
      assign jump_target = instr[PC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (jump)
      pc <= jump_target;
    else if (branch && zero)
      pc <= br_target;
    else
      pc <= pc_plus1;
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Bench for exec_ctrl_unit: directed checks plus random instructions against a behavioural model.
module tb_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rs_data, rt_data;
  logic [31:0] pc;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic        reg_write, mem_write, mem_read, reg_dst, alu_src, mem_to_reg, branch, jump;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero, illegal;

  typedef struct packed {
    logic        reg_write, mem_write, mem_read, reg_dst, alu_src, mem_to_reg, branch, jump;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  exp_t        e;

  exec_ctrl_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .pc(pc), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .opcode(opcode), .funct(funct),
    .imm(imm), .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .branch(branch),
    .jump(jump), .alu_op(alu_op), .alu_result(alu_result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Reference: control table by opcode, then the arithmetic rule the ALU mode selects.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rtd);
    exp_t        r;
    logic [31:0] b;
    logic        shift_ok;
    r = '0;
`ifdef ALU_SHIFT_EN
    shift_ok = 1'b1;
`else
    shift_ok = 1'b0;
`endif
    case (ins[31:26])
      6'h00: begin r.reg_write = 1; r.reg_dst = 1; r.alu_op = 2'b10; end
      6'h23: begin r.reg_write = 1; r.mem_read = 1; r.mem_to_reg = 1; r.alu_src = 1; end
      6'h2B: begin r.mem_write = 1; r.alu_src = 1; end
      6'h08: begin r.reg_write = 1; r.alu_src = 1; end
      6'h04: begin r.branch = 1; r.alu_op = 2'b01; end
      6'h02: r.jump = 1;
      default: r.illegal = 1;
    endcase
    b = r.alu_src ? 32'(signed'(ins[15:0])) : rtd;
    if (r.alu_op == 2'b00) r.result = a + b;
    else if (r.alu_op == 2'b01) r.result = a - b;
    else begin
      case (ins[5:0])
        6'h20: r.result = a + b;
        6'h22: r.result = a - b;
        6'h24: r.result = a & b;
        6'h25: r.result = a | b;
        6'h2A: r.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'h00: r.result = shift_ok ? rtd << ins[10:6] : 32'd0;
        6'h02: r.result = shift_ok ? rtd >> ins[10:6] : 32'd0;
        default: r.result = 32'd0;
      endcase
      if (!(ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) &&
          !(shift_ok && (ins[5:0] inside {6'h00, 6'h02}))) begin
        r.reg_write = 0;
        r.illegal   = 1;
      end
    end
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr = ins; rs_data = a; rt_data = b;
    #1;
    e = model(ins, a, b);
    check("ctrl", {reg_write, mem_write, mem_read, reg_dst, alu_src, mem_to_reg, branch, jump, alu_op, illegal},
                  {e.reg_write, e.mem_write, e.mem_read, e.reg_dst, e.alu_src, e.mem_to_reg, e.branch, e.jump, e.alu_op, e.illegal});
    check("alu", alu_result, e.result);
    check("zero", zero, e.zero);
    check("fields", {opcode, rs, rt, rd, shamt, funct, imm},
                    {ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0], ins[15:0]});
  endtask

  task automatic tick();
    logic [31:0] p1;
    p1 = m_pc + 32'd1;
    if (reset) m_pc = 32'd0;
    else if (e.jump) m_pc = {p1[31:26], instr[25:0]};
    else if (e.branch && e.zero) m_pc = p1 + 32'(signed'(instr[15:0]));
    else m_pc = p1;
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
  endtask

  initial begin
    logic [31:0] ins, a, b;
    logic [5:0]  fn;
    m_pc  = 32'd0;
    reset = 1'b1;
    apply(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_pc", pc, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      apply(32'h0, 32'h0, 32'h0);
      tick();
      check("pc_seq", pc, 32'(i));
    end

    apply(32'h00011020, 32'd1, 32'd2);
    check("add_res", alu_result, 32'd3);
    check("add_ctl", {reg_write, reg_dst, illegal}, 3'b110);
    tick();

    apply(32'h1022FFFE, 32'd7, 32'd7);
    check("beq_zero", zero, 1'b1);
    tick();
    check("beq_taken", pc, 32'd3);

    apply(32'h00642822, 32'd5, 32'd1);
    check("sub_res", alu_result, 32'd4);
    tick();

    apply(32'h1022FFFE, 32'd7, 32'd8);
    tick();
    check("beq_not", pc, 32'd5);

    apply(32'h00642822, 32'd1, 32'd5);
    check("sub_neg", alu_result, 32'hFFFFFFFC);
    check("sub_nz", zero, 1'b0);
    tick();

    apply(32'h8CC40001, 32'd0, 32'h12345678);
    check("lw_res", alu_result, 32'd1);
    check("lw_ctl", {mem_read, mem_to_reg, reg_dst}, 3'b110);
    tick();

    apply(32'hACC40002, 32'd0, 32'h0BADF00D);
    check("sw_res", alu_result, 32'd2);
    check("sw_ctl", {mem_write, reg_write}, 2'b10);
    tick();

    apply(32'h08000009, 32'd3, 32'd4);
    tick();
    check("j_pc", pc, 32'd9);

    apply(32'h000110C0, 32'd0, 32'd1);
`ifdef ALU_SHIFT_EN
    check("sll_res", alu_result, 32'd8);
    check("sll_ctl", {illegal, reg_write}, 2'b01);
`else
    check("sll_ctl", {illegal, reg_write}, 2'b10);
`endif
    tick();

    apply(32'hFC000000, 32'd1, 32'd2);
    check("ill_op", illegal, 1'b1);
    check("ill_strb", {reg_write, mem_write, mem_read, reg_dst, alu_src, mem_to_reg, branch, jump}, 8'h00);
    tick();
    check("ill_pc", pc, 32'd11);

    reset = 1'b1;
    apply(32'h08000009, 32'd0, 32'd0);
    tick();
    check("mid_rst", pc, 32'd0);
    reset = 1'b0;

    apply(32'h1000FFFD, 32'd3, 32'd3);
    tick();
    check("br_wrap", pc, 32'hFFFFFFFE);
    apply(32'h00011020, 32'd1, 32'd2);
    tick();
    apply(32'h00011020, 32'd1, 32'd2);
    tick();
    check("pc_wrap", pc, 32'd0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0, 1: begin
          case ($urandom_range(0, 7))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h2A; 5: fn = 6'h00; 6: fn = 6'h02;
            default: fn = 6'($urandom);
          endcase
          ins[31:26] = 6'h00;
          ins[5:0]   = fn;
        end
        2: ins[31:26] = 6'h23;
        3: ins[31:26] = 6'h2B;
        4: ins[31:26] = 6'h08;
        5: ins[31:26] = 6'h04;
        6: ins[31:26] = 6'h02;
        default: ins[31:26] = 6'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      reset = ($urandom_range(0, 49) == 0);
      apply(ins, a, b);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
